// File: rtl/bus_source_encoder.sv
// Bus source encoder: turns one-hot "out" requests from the control unit into
// a registered mux select code and a one-hot grant. A round-robin arbiter
// resolves multiple requests and keeps the current owner until it releases.
// Multi-driver cycles are flagged (sticky) and counted (saturating).
//
// Handshake: a source raises out_req[i] and holds it for as long as it needs
// the bus. grant[i], select_signal and bus_valid follow one clock later and
// stay put until out_req[i] drops. There is no preemption.
module bus_source_encoder #(
    parameter int NUM_SRC  = 24,
    parameter int SEL_W    = 5,
    parameter int IDLE_SEL = 31,
    parameter int CNT_W    = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] out_req,
    output logic [SEL_W-1:0]   select_signal,
    output logic [NUM_SRC-1:0] grant,
    output logic               bus_valid,
    output logic               conflict,
    output logic [CNT_W-1:0]   conflict_count,
    output logic               state_dbg
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0]   IDLE_CODE = SEL_W'(IDLE_SEL);
    localparam logic [SEL_W-1:0]   LAST_INIT = SEL_W'(NUM_SRC - 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0  = NUM_SRC'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               conflict_q, conflict_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               owner_held;
    logic               multi_req;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    // Round-robin search: first set request at or after last+1, wrapping at NUM_SRC.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            idx = int'(last_q) + 1 + off;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!pick_found && out_req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(idx);
            end
        end
    end

    // Next-state logic for ownership, select code and conflict tracking.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        last_d     = last_q;
        conflict_d = conflict_q;
        count_d    = count_q;

        // The owner keeps the bus for as long as its own request stays high.
        owner_held = (state_q == S_GRANT) && ((out_req & grant_q) != '0);
        // Two or more bits set: clearing the lowest set bit leaves something.
        multi_req  = (out_req & (out_req - ONE_HOT0)) != '0;

        if (owner_held) begin
            state_d = S_GRANT;
        end else if (pick_found) begin
            // Covers both a fresh grant from idle and a direct handover.
            state_d = S_GRANT;
            sel_d   = pick_idx;
            grant_d = ONE_HOT0 << pick_idx;
            valid_d = 1'b1;
            last_d  = pick_idx;
        end else begin
            state_d = S_IDLE;
            sel_d   = IDLE_CODE;
            grant_d = '0;
            valid_d = 1'b0;
        end

        if (multi_req) begin
            conflict_d = 1'b1;
            if (count_q != '1) count_d = count_q + CNT_ONE;
        end
    end

    // State registers; clear wins over everything, including a live grant.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_IDLE;
            sel_q      <= IDLE_CODE;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= LAST_INIT;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
        end
    end

    assign select_signal  = sel_q;
    assign grant          = grant_q;
    assign bus_valid      = valid_q;
    assign conflict       = conflict_q;
    assign conflict_count = count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_bus_source_encoder.sv
// Directed bench for bus_source_encoder. Each stimulus vector carries the
// hand-computed select code expected one clock later; granted codes go into
// exp_q and a negedge monitor pops them whenever bus_valid is high.
module tb_bus_source_encoder;

  logic        clock;
  logic        clear;
  logic [23:0] out_req;
  logic [4:0]  select_signal;
  logic [23:0] grant;
  logic        bus_valid;
  logic        conflict;
  logic [7:0]  conflict_count;
  logic        state_dbg;

  logic [4:0]  exp_q[$];
  int          total;
  int          bad;
  logic        mon_en;

  bus_source_encoder dut (
    .clock          (clock),
    .clear          (clear),
    .out_req        (out_req),
    .select_signal  (select_signal),
    .grant          (grant),
    .bus_valid      (bus_valid),
    .conflict       (conflict),
    .conflict_count (conflict_count),
    .state_dbg      (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply req for one clock; exp_sel is the select expected after the edge
  task automatic step(input logic [23:0] req, input logic [4:0] exp_sel);
    out_req = req;
    if (exp_sel != 5'd31) exp_q.push_back(exp_sel);
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear(input logic [23:0] req);
    clear   = 1'b1;
    out_req = req;
    @(posedge clock);
    #1;
    clear   = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {27'd0, select_signal}, 32'd31);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("mon_select", {27'd0, select_signal}, {27'd0, e});
          chk("mon_grant", {8'd0, grant}, {8'd0, 24'd1 << e});
        end
      end else begin
        chk("mon_idle_select", {27'd0, select_signal}, 32'd31);
        chk("mon_idle_grant", {8'd0, grant}, 32'd0);
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    mon_en  = 1'b0;
    clear   = 1'b1;
    out_req = 24'hFFFFFF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_select", {27'd0, select_signal}, 32'd31);
    chk("rst_grant", {8'd0, grant}, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_conflict", {31'd0, conflict}, 32'd0);
    chk("rst_count", {24'd0, conflict_count}, 32'd0);
    clear   = 1'b0;
    out_req = 24'd0;
    mon_en  = 1'b1;

    // single source PC
    step(24'h100000, 5'd20);
    step(24'h100000, 5'd20);
    step(24'h100000, 5'd20);
    step(24'h000000, 5'd31);
    chk("single_conflict", {31'd0, conflict}, 32'd0);

    // round robin between 3 and 21, starting fresh from source 0
    do_clear(24'd0);
    step((24'd1 << 3) | (24'd1 << 21), 5'd3);
    step((24'd1 << 21), 5'd21);
    step((24'd1 << 3) | (24'd1 << 21), 5'd21);
    step((24'd1 << 3), 5'd3);
    step(24'd0, 5'd31);
    chk("rr_conflict", {31'd0, conflict}, 32'd1);
    chk("rr_count", {24'd0, conflict_count}, 32'd2);

    // wrap-around: 23 releases with 0 and 22 pending
    step((24'd1 << 23), 5'd23);
    step((24'd1 << 0) | (24'd1 << 22), 5'd0);
    chk("wrap_handover_select", {27'd0, select_signal}, 32'd0);
    chk("wrap_handover_valid", {31'd0, bus_valid}, 32'd1);
    step(24'd0, 5'd31);
    chk("wrap_count", {24'd0, conflict_count}, 32'd3);

    // no preemption, then clear in the middle of a grant
    step((24'd1 << 5), 5'd5);
    step((24'd1 << 5) | (24'd1 << 2), 5'd5);
    step((24'd1 << 5), 5'd5);
    step((24'd1 << 5) | (24'd1 << 2), 5'd5);
    chk("nopre_count", {24'd0, conflict_count}, 32'd5);
    do_clear(24'd1 << 5);
    chk("midclr_select", {27'd0, select_signal}, 32'd31);
    chk("midclr_grant", {8'd0, grant}, 32'd0);
    chk("midclr_valid", {31'd0, bus_valid}, 32'd0);
    chk("midclr_conflict", {31'd0, conflict}, 32'd0);
    chk("midclr_count", {24'd0, conflict_count}, 32'd0);
    // search restarts at 0, so 5 beats 7
    step((24'd1 << 5) | (24'd1 << 7), 5'd5);
    step(24'd0, 5'd31);
    chk("post_clr_count", {24'd0, conflict_count}, 32'd1);

    // saturation: count is 1, hold two requests for 300 cycles
    for (int i = 0; i < 300; i++) begin
      step((24'd1 << 1) | (24'd1 << 2), 5'd1);
      if (i == 252) chk("sat_254", {24'd0, conflict_count}, 32'd254);
      if (i == 253) chk("sat_255", {24'd0, conflict_count}, 32'd255);
    end
    chk("sat_hold", {24'd0, conflict_count}, 32'd255);
    chk("sat_conflict", {31'd0, conflict}, 32'd1);
    step(24'd0, 5'd31);
    step(24'd0, 5'd31);

    @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_source_encoder.md
Name: bus_source_encoder

Overview:
Generates the 5-bit select_signal that drives the datapath bus multiplexer. It converts one-hot "out" requests from the control unit (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout) into a registered select code and a one-hot grant. When several sources request the bus, a round-robin arbiter picks one and holds it until that source releases. It also flags and counts multi-driver cycles so the control FSM can detect them during bring-up.

Parameters:
NUM_SRC, 24, number of bus sources; bit i of out_req maps to select code i.
SEL_W, 5, width of select_signal.
IDLE_SEL, 31, select code driven when no source holds the bus; it is an unmapped code, so the mux outputs 32'd0.
CNT_W, 8, width of the saturating conflict counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous, active-high reset.
out_req  input  NUM_SRC  one-hot bus requests. Bit order: 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = InPort, 23 = C_sign_extended.
select_signal  output  SEL_W  registered select code to the bus mux.
grant  output  NUM_SRC  registered one-hot grant; bit i is high while source i owns the bus.
bus_valid  output  1  high while any grant is active.
conflict  output  1  sticky flag, set on any cycle with two or more requests high.
conflict_count  output  CNT_W  saturating count of conflict cycles.

Behaviour:
Reset (clear high at a rising edge):
- select_signal = IDLE_SEL.
- grant = 0, bus_valid = 0.
- conflict = 0, conflict_count = 0.
- FSM goes to IDLE.
- Round-robin pointer last = NUM_SRC-1, so the first search starts at source 0.
- clear overrides all other activity in that cycle, including a grant in progress. The grant drops at that edge.

FSM states:
- IDLE:
  - No requests: stay in IDLE; select_signal = IDLE_SEL, grant = 0.
  - Any request: search from (last+1) mod NUM_SRC upward, wrapping past 23 to 0. Take the first set bit k. At the next edge: grant = 1<<k, select_signal = k, bus_valid = 1, last = k, state goes to GRANT.
- GRANT (owner k):
  - out_req[k] still high: hold grant and select unchanged, whatever other requests do. There is no preemption.
  - out_req[k] low and other requests pending: arbitrate the same cycle, searching from k+1 with wrap. At the next edge the new owner takes over directly, with no idle cycle between owners.
  - out_req[k] low and nothing pending: at the next edge, return to IDLE with select_signal = IDLE_SEL, grant = 0, bus_valid = 0.

Latency and handshake:
- Grant latency is exactly 1 cycle from request to grant/select.
- A source must hold out_req high for as long as it needs the bus.
- A single-cycle request yields a single-cycle grant, delayed by 1 cycle.

Conflict detection (evaluated every non-clear cycle, independent of FSM state):
- If popcount(out_req) >= 2 at a rising edge: conflict is set to 1 and stays set until clear.
- conflict_count increments on each such edge and saturates at 2^CNT_W-1 without wrapping.

Invariants and bounds:
- grant is always one-hot or zero.
- select_signal equals the index of the grant bit, or IDLE_SEL when grant = 0.
- Out-of-range codes 24..30 are never driven.
- All outputs are registered; there is no combinational path from out_req to the outputs.

Test Plan:
- Reset: clear for 2 cycles with out_req = 24'hFFFFFF -> select_signal = 31, grant = 0, bus_valid = 0, conflict = 0, conflict_count = 0.
- Single source: out_req = 1<<20 (PC) for 3 cycles, then 0 -> select_signal = 20 and grant = 24'h100000 for cycles 2-4. select_signal = 31 on cycle 5.
- Round robin: after reset, hold out_req = bits {3, 21} and release each owner for one cycle after it is granted -> grant order is 3, 21, 3. conflict = 1, and conflict_count equals the number of multi-request edges.
- Wrap-around: owner 23 (Cout) releases while bits {0, 22} are pending -> next owner is 0, not 22. The handover happens with no IDLE cycle.
- No preemption plus mid-operation reset: hold bit 5 while pulsing bit 2 -> grant stays on 5. Assert clear mid-grant -> next cycle select = 31, grant = 0, conflict = 0. The next request for bit 5 is granted with the search starting at 0.
- Saturation: hold 2 requests for 300 cycles with CNT_W = 8 -> conflict_count stops at 255.
